// File: rtl/vend_pkg.sv
// Shared definitions for the multi-product vending controller.
// Holds the one-hot state encoding, coin values (in nickels) and the
// one-hot change_coin codes used by the controller and change selector.
package vend_pkg;

  // One-hot controller states
  typedef enum logic [4:0] {
    ST_DEPOSIT = 5'b00001,
    ST_SERVE1  = 5'b00010,
    ST_SERVE2  = 5'b00100,
    ST_CHANGE1 = 5'b01000,
    ST_CHANGE2 = 5'b10000
  } state_t;

  // Coin values in nickels
  localparam int VAL_NICKEL  = 1;
  localparam int VAL_DIME    = 2;
  localparam int VAL_QUARTER = 5;

  // change_coin encoding: {quarter, dime, nickel}
  localparam logic [2:0] COIN_NONE    = 3'b000;
  localparam logic [2:0] COIN_NICKEL  = 3'b001;
  localparam logic [2:0] COIN_DIME    = 3'b010;
  localparam logic [2:0] COIN_QUARTER = 3'b100;

endpackage

// File: rtl/vend_change_sel.sv
// Purpose: picks the largest coin not exceeding the remaining credit.
// Latency: combinational.
// Backpressure: none; pure function of credit.
// Ports: credit (in, CW) -> coin (one-hot {q,d,n}), value (coin value in nickels).
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic [CW-1:0] credit,
  output logic [2:0]    coin,
  output logic [CW-1:0] value
);

  always_comb begin
    coin  = COIN_NONE;
    value = '0;
    if (credit >= CW'(VAL_QUARTER)) begin
      coin  = COIN_QUARTER;
      value = CW'(VAL_QUARTER);
    end else if (credit >= CW'(VAL_DIME)) begin
      coin  = COIN_DIME;
      value = CW'(VAL_DIME);
    end else if (credit != '0) begin
      // zero credit never reaches the change states; report no coin there
      coin  = COIN_NICKEL;
      value = CW'(VAL_NICKEL);
    end
  end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Purpose: multi-product vending controller with saturating credit and largest-coin-first change.
// Latency: coin -> credit 1 cycle; dispense -> serve pulse 1 cycle; coin_rej/low_credit same cycle.
// Backpressure: dispenser/hopper level handshake on done; coins refused (coin_rej) while busy.
// Ports: clk, rst_n (async active-low); nickel/dime/quarter strobes; dispense + sel;
//        done handshake; serve/serve_sel, change/change_coin, coin_rej, low_credit, busy, credit.
// Option: define VEND_CANCEL_EN to add the cancel input (returns the full credit as change).
module vend_ctrl_multi
  import vend_pkg::*;
#(
  parameter int                  NPROD      = 4,
  parameter int                  SW         = (NPROD > 1) ? $clog2(NPROD) : 1,
  parameter int                  CW         = 8,
  parameter logic [NPROD*CW-1:0] PRICES     = {8'd13, 8'd10, 8'd7, 8'd5},
  parameter int                  MAX_CREDIT = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          nickel,
  input  logic          dime,
  input  logic          quarter,
  input  logic          dispense,
  input  logic [SW-1:0] sel,
`ifdef VEND_CANCEL_EN
  input  logic          cancel,
`endif
  input  logic          done,
  output logic          serve,
  output logic [SW-1:0] serve_sel,
  output logic          change,
  output logic [2:0]    change_coin,
  output logic          coin_rej,
  output logic          low_credit,
  output logic          busy,
  output logic [CW-1:0] credit
);

  state_t        state;
  logic          first;     // high during the first cycle after entering SERVE1/CHANGE1
  logic [CW-1:0] credit_q;
  logic [SW-1:0] sel_q;
  logic [2:0]    coin_q;    // coin being ejected, held after the first CHANGE1 cycle

  logic          in_dep;
  logic [1:0]    n_strobe;
  logic [CW:0]   coin_val;
  logic [CW:0]   sum;
  logic          coin_ok;
  logic [CW-1:0] price;
  logic          sel_ok;
  logic          buy_ok;
  logic          cancel_go;
  logic          coin_acc;
  logic [2:0]    cs_coin;
  logic [CW-1:0] cs_val;

  assign in_dep   = (state == ST_DEPOSIT);
  assign n_strobe = {1'b0, nickel} + {1'b0, dime} + {1'b0, quarter};

  always_comb begin
    coin_val = '0;
    if (quarter)      coin_val = (CW+1)'(VAL_QUARTER);
    else if (dime)    coin_val = (CW+1)'(VAL_DIME);
    else if (nickel)  coin_val = (CW+1)'(VAL_NICKEL);
  end

  // One bit of headroom so the ceiling compare cannot wrap
  assign sum     = {1'b0, credit_q} + coin_val;
  assign coin_ok = (n_strobe == 2'd1) && (sum <= (CW+1)'(MAX_CREDIT));

  // Price lookup; a select outside the product range yields sel_ok = 0
  always_comb begin
    price  = '0;
    sel_ok = 1'b0;
    for (int i = 0; i < NPROD; i++) begin
      if (sel == SW'(i)) begin
        price  = PRICES[i*CW +: CW];
        sel_ok = 1'b1;
      end
    end
  end

  assign buy_ok = in_dep && dispense && sel_ok && (credit_q >= price);

`ifdef VEND_CANCEL_EN
  assign cancel_go = in_dep && !dispense && cancel && (credit_q != '0);
`else
  assign cancel_go = 1'b0;
`endif

  // dispense (accepted or not) and cancel both pre-empt a coin in the same cycle
  assign coin_acc   = in_dep && !dispense && !cancel_go && coin_ok;
  assign coin_rej   = (n_strobe != 2'd0) && !coin_acc;
  assign low_credit = in_dep && dispense && !buy_ok;

  vend_change_sel #(.CW(CW)) u_change_sel (
    .credit (credit_q),
    .coin   (cs_coin),
    .value  (cs_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_DEPOSIT;
      first    <= 1'b0;
      credit_q <= '0;
      sel_q    <= '0;
      coin_q   <= COIN_NONE;
    end else begin
      first <= 1'b0;
      unique case (state)
        ST_DEPOSIT: begin
          if (buy_ok) begin
            credit_q <= credit_q - price;
            sel_q    <= sel;
            state    <= ST_SERVE1;
            first    <= 1'b1;
          end else if (cancel_go) begin
            state <= ST_CHANGE1;
            first <= 1'b1;
          end else if (coin_acc) begin
            credit_q <= sum[CW-1:0];
          end
        end
        ST_SERVE1: begin
          if (done) state <= ST_SERVE2;
        end
        ST_SERVE2: begin
          if (!done) begin
            if (credit_q == '0) begin
              state <= ST_DEPOSIT;
            end else begin
              state <= ST_CHANGE1;
              first <= 1'b1;
            end
          end
        end
        ST_CHANGE1: begin
          // Commit the coin once per entry; done may arrive in the same cycle
          if (first) begin
            credit_q <= credit_q - cs_val;
            coin_q   <= cs_coin;
          end
          if (done) state <= ST_CHANGE2;
        end
        ST_CHANGE2: begin
          if (!done) begin
            if (credit_q == '0) begin
              state <= ST_DEPOSIT;
            end else begin
              state <= ST_CHANGE1;
              first <= 1'b1;
            end
          end
        end
        default: state <= ST_DEPOSIT;
      endcase
    end
  end

  assign serve     = (state == ST_SERVE1) && first;
  assign change    = (state == ST_CHANGE1) && first;
  assign serve_sel = (state == ST_SERVE1 || state == ST_SERVE2) ? sel_q : '0;
  // First CHANGE1 cycle shows the live selection; coin_q holds it afterwards
  assign change_coin = change ? cs_coin :
                       (state == ST_CHANGE1 || state == ST_CHANGE2) ? coin_q : COIN_NONE;
  assign busy      = !in_dep;
  assign credit    = credit_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Bench for vend_ctrl_multi: coin table, directed purchase/change/reset
// sequences, and randomized traffic checked against an arithmetic model.
module tb_vend_ctrl_multi;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0, dispense = 1'b0, done = 1'b0;
  logic [1:0] sel = 2'd0;
`ifdef VEND_CANCEL_EN
  logic       cancel = 1'b0;
`endif

  logic       serve, change, coin_rej, low_credit, busy;
  logic [1:0] serve_sel;
  logic [2:0] change_coin;
  logic [7:0] credit;

  logic       serve3, change3, coin_rej3, low_credit3, busy3;
  logic [1:0] serve_sel3;
  logic [2:0] change_coin3;
  logic [7:0] credit3;

  vend_ctrl_multi dut (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime), .quarter(quarter),
    .dispense(dispense), .sel(sel),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .done(done), .serve(serve), .serve_sel(serve_sel), .change(change),
    .change_coin(change_coin), .coin_rej(coin_rej), .low_credit(low_credit),
    .busy(busy), .credit(credit)
  );

  // Three-product variant so an out-of-range select can be exercised
  vend_ctrl_multi #(.NPROD(3), .PRICES(24'h0A_07_05)) dut3 (
    .clk(clk), .rst_n(rst_n), .nickel(nickel), .dime(dime), .quarter(quarter),
    .dispense(dispense), .sel(sel),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .done(done), .serve(serve3), .serve_sel(serve_sel3), .change(change3),
    .change_coin(change_coin3), .coin_rej(coin_rej3), .low_credit(low_credit3),
    .busy(busy3), .credit(credit3)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int got[$];
  int price_of[4] = '{5, 7, 10, 13};

  typedef struct {
    logic [2:0] s;     // {quarter, dime, nickel}
    int         rej;
    int         cr;
  } coin_vec_t;
  coin_vec_t tab[15];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    {quarter, dime, nickel} = 3'b000;
    dispense = 1'b0;
    done     = 1'b0;
    sel      = 2'd0;
`ifdef VEND_CANCEL_EN
    cancel   = 1'b0;
`endif
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  function automatic int coin_value(input logic [2:0] c);
    case (c)
      3'b100:  return 5;
      3'b010:  return 2;
      3'b001:  return 1;
      default: return 9;
    endcase
  endfunction

  // Sequence of coin values folded into decimal digits, e.g. 5,2,1 -> 521
  function automatic int greedy_code(input int c);
    int code;
    code = 0;
    for (int i = 0; i < c / 5; i++) code = code * 10 + 5;
    for (int i = 0; i < (c % 5) / 2; i++) code = code * 10 + 2;
    for (int i = 0; i < (c % 5) % 2; i++) code = code * 10 + 1;
    return code;
  endfunction

  function automatic int got_code();
    int code;
    code = 0;
    foreach (got[i]) code = code * 10 + got[i];
    return code;
  endfunction

  // Apply a coin pattern for one cycle, check refusal mid-cycle and credit after the edge
  task automatic put(input logic [2:0] s, input int exp_rej, input int exp_cr, input string nm);
    {quarter, dime, nickel} = s;
    #3;
    check({nm, " coin_rej"}, int'(coin_rej), exp_rej);
    step();
    {quarter, dime, nickel} = 3'b000;
    check({nm, " credit"}, int'(credit), exp_cr);
  endtask

  // Acts as dispenser/hopper: after each serve/change pulse waits 'hold' cycles,
  // raises done for one cycle, and records ejected coins until the DUT is idle.
  task automatic drain(input int hold, output int nserve, output int tmo);
    int wait_cnt;
    bit pending;
    got.delete();
    nserve   = 0;
    pending  = 1'b0;
    wait_cnt = 0;
    tmo      = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      #3;
      if (!busy) begin
        tmo = 0;
        break;
      end
      if (serve) nserve++;
      if (change) got.push_back(coin_value(change_coin));
      if (serve || change) begin
        pending  = 1'b1;
        wait_cnt = hold;
      end
      step();
      if (done) done = 1'b0;
      else if (pending) begin
        if (wait_cnt == 0) begin
          done    = 1'b1;
          pending = 1'b0;
        end else wait_cnt--;
      end
    end
    done = 1'b0;
    step();
  endtask

  initial begin
    int ns, tmo, m, r, cnt, val, ok, rej, hold;
    logic [2:0] s;

    tab = '{
      '{3'b100, 0, 5},  '{3'b100, 0, 10}, '{3'b100, 0, 15}, '{3'b100, 0, 20},
      '{3'b100, 0, 25}, '{3'b100, 0, 30}, '{3'b100, 0, 35}, '{3'b010, 0, 37},
      '{3'b001, 0, 38}, '{3'b100, 1, 38}, '{3'b011, 1, 38}, '{3'b010, 0, 40},
      '{3'b001, 1, 40}, '{3'b000, 0, 40}, '{3'b111, 1, 40}
    };

    // Reset state
    #2;
    rst_n = 1'b0;
    step();
    check("rst busy", int'(busy), 0);
    check("rst credit", int'(credit), 0);
    check("rst serve", int'(serve), 0);
    check("rst change", int'(change), 0);
    check("rst change_coin", int'(change_coin), 0);
    check("rst serve_sel", int'(serve_sel), 0);
    rst_n = 1'b1;
    step();

    // Coin table: accumulation, ceiling, multiple strobes
    foreach (tab[i]) put(tab[i].s, tab[i].rej, tab[i].cr, $sformatf("tab%0d", i));

    // Purchase at price 10 with dime change
    do_reset();
    put(3'b100, 0, 5, "t1 q");
    put(3'b100, 0, 10, "t1 q");
    put(3'b010, 0, 12, "t1 d");
    dispense = 1'b1; sel = 2'd2;
    #3;
    check("t1 low_credit", int'(low_credit), 0);
    step();
    dispense = 1'b0;
    check("t1 serve", int'(serve), 1);
    check("t1 serve_sel", int'(serve_sel), 2);
    check("t1 credit", int'(credit), 2);
    drain(0, ns, tmo);
    check("t1 timeout", tmo, 0);
    check("t1 nserve", ns, 1);
    check("t1 change seq", got_code(), 2);
    check("t1 credit end", int'(credit), 0);

    // Insufficient credit and invalid select
    do_reset();
    put(3'b010, 0, 2, "t4 d");
    put(3'b010, 0, 4, "t4 d");
    dispense = 1'b1; sel = 2'd0;
    #3;
    check("t4 low_credit", int'(low_credit), 1);
    step();
    dispense = 1'b0;
    check("t4 busy", int'(busy), 0);
    check("t4 credit", int'(credit), 4);
    for (int i = 0; i < 3; i++) put(3'b100, 0, 9 + 5 * i, "t4 q");
    dispense = 1'b1; sel = 2'd3; quarter = 1'b1;
    #3;
    check("t4 low_credit np3", int'(low_credit3), 1);
    check("t4 low_credit np4", int'(low_credit), 0);
    check("t4 coin_rej on dispense", int'(coin_rej), 1);
    step();
    dispense = 1'b0; quarter = 1'b0;
    check("t4 busy np3", int'(busy3), 0);
    check("t4 credit np3", int'(credit3), 19);
    check("t4 serve np4", int'(serve), 1);
    drain(1, ns, tmo);
    check("t4 timeout", tmo, 0);
    check("t4 change seq", got_code(), 51);

    // Three-coin change with done held off for 10 cycles per coin
    do_reset();
    put(3'b100, 0, 5, "t5 q");
    put(3'b100, 0, 10, "t5 q");
    put(3'b010, 0, 12, "t5 d");
    put(3'b001, 0, 13, "t5 n");
    dispense = 1'b1; sel = 2'd0;
    step();
    dispense = 1'b0;
    check("t5 credit", int'(credit), 8);
    drain(10, ns, tmo);
    check("t5 timeout", tmo, 0);
    check("t5 nserve", ns, 1);
    check("t5 change seq", got_code(), 521);
    check("t5 busy end", int'(busy), 0);

    // Asynchronous reset while waiting in SERVE2
    do_reset();
    put(3'b100, 0, 5, "t6 q");
    put(3'b100, 0, 10, "t6 q");
    dispense = 1'b1; sel = 2'd1;
    step();
    dispense = 1'b0;
    done = 1'b1;
    check("t6 credit", int'(credit), 3);
    check("t6 serve_sel", int'(serve_sel), 1);
    step();
    step();
    check("t6 busy serve2", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 busy", int'(busy), 0);
    check("t6 credit rst", int'(credit), 0);
    check("t6 serve_sel rst", int'(serve_sel), 0);
    check("t6 change rst", int'(change), 0);
    check("t6 change_coin rst", int'(change_coin), 0);
    check("t6 serve rst", int'(serve), 0);
    done = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef VEND_CANCEL_EN
    // Cancel returns the full credit; a coin in the same cycle is refused
    do_reset();
    put(3'b100, 0, 5, "tc q");
    put(3'b010, 0, 7, "tc d");
    cancel = 1'b1; quarter = 1'b1;
    #3;
    check("tc coin_rej", int'(coin_rej), 1);
    step();
    cancel = 1'b0; quarter = 1'b0;
    check("tc busy", int'(busy), 1);
    drain(2, ns, tmo);
    check("tc timeout", tmo, 0);
    check("tc nserve", ns, 0);
    check("tc change seq", got_code(), 52);
    check("tc credit end", int'(credit), 0);
`endif

    // Randomized traffic against the arithmetic model
    do_reset();
    m = 0;
    for (int it = 0; it < 400; it++) begin
      r = $urandom_range(0, 99);
      if (r < 80) begin
        if (r < 60) begin
          case ($urandom_range(0, 2))
            0:       s = 3'b001;
            1:       s = 3'b010;
            default: s = 3'b100;
          endcase
        end else s = 3'($urandom_range(0, 7));
        cnt = int'(s[0]) + int'(s[1]) + int'(s[2]);
        val = s[2] ? 5 : (s[1] ? 2 : (s[0] ? 1 : 0));
        ok  = (cnt == 1 && m + val <= 40) ? 1 : 0;
        rej = (cnt > 0 && ok == 0) ? 1 : 0;
        if (ok == 1) m += val;
        put(s, rej, m, "rnd coin");
      end else begin
        sel = 2'($urandom_range(0, 3));
        s = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
        {quarter, dime, nickel} = s;
        dispense = 1'b1;
        #3;
        check("rnd low_credit", int'(low_credit), (m < price_of[sel]) ? 1 : 0);
        check("rnd coin_rej disp", int'(coin_rej), (s != 3'b000) ? 1 : 0);
        step();
        dispense = 1'b0;
        {quarter, dime, nickel} = 3'b000;
        if (m < price_of[sel]) begin
          check("rnd credit kept", int'(credit), m);
        end else begin
          m -= price_of[sel];
          check("rnd serve", int'(serve), 1);
          check("rnd serve_sel", int'(serve_sel), int'(sel));
          check("rnd credit after buy", int'(credit), m);
          hold = $urandom_range(0, 3);
          drain(hold, ns, tmo);
          check("rnd timeout", tmo, 0);
          check("rnd change seq", got_code(), greedy_code(m));
          check("rnd credit end", int'(credit), 0);
          m = 0;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
